// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - default address/data width and instruction width
//   - arbiter FSM state encoding
package dmem_arb_pkg;

  localparam int REGSIZE_DEF = 64;
  localparam int BITSIZE_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker with its priority pointer.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_en        : picker may grant this cycle (arbiter idle)
//   i_valid[1:0]: pending requests
//   o_grant[1:0]: one-hot grant (or zero); combinational from i_valid
// Because a grant is only issued while the arbiter accepts, any non-zero
// grant is a completed handshake, which is the only thing that moves the
// pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);

  // 0: req0 wins a tie, 1: req1 wins a tie
  logic       r_prio;
  logic [1:0] w_grant;

  always_comb begin
    w_grant = 2'b00;
    if (i_en) begin
      if (i_valid == 2'b11) begin
        w_grant = r_prio ? 2'b10 : 2'b01;
      end else begin
        w_grant = i_valid;
      end
    end
  end

  // Prefer the requester that was not just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (|w_grant) begin
      r_prio <= ~w_grant[1];
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two load/store requesters onto a single Data_memory port.
// Each access takes three cycles: IDLE (handshake), ACCESS (memory strobe),
// RESP (one-cycle completion pulse to the requester that was served).
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   reqN_valid/ready/write      : request handshake and store flag (N=0,1)
//   reqN_addr/wdata             : byte address and store data
//   rspN_valid/rdata            : completion pulse and load data
//   Addr, WriteData, MemWrite, MemRead : to Data_memory
//   DMout                       : combinational read data from Data_memory
//   busy                        : access in progress (ACCESS or RESP)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int REGSIZE = REGSIZE_DEF,
  parameter int BITSIZE = BITSIZE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic               req0_write,
  input  logic [REGSIZE-1:0] req0_addr,
  input  logic [REGSIZE-1:0] req0_wdata,
  output logic               rsp0_valid,
  output logic [REGSIZE-1:0] rsp0_rdata,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic               req1_write,
  input  logic [REGSIZE-1:0] req1_addr,
  input  logic [REGSIZE-1:0] req1_wdata,
  output logic               rsp1_valid,
  output logic [REGSIZE-1:0] rsp1_rdata,
  output logic [REGSIZE-1:0] Addr,
  output logic [REGSIZE-1:0] WriteData,
  output logic               MemWrite,
  output logic               MemRead,
  input  logic [REGSIZE-1:0] DMout,
  output logic               busy
);

  // Instruction width is part of the interface only; no logic depends on it.
  localparam int unused_bitsize = BITSIZE;

  arb_state_t         r_state;
  arb_state_t         w_state_next;
  logic               r_write;
  logic [REGSIZE-1:0] r_addr;
  logic [REGSIZE-1:0] r_wdata;
  logic               r_id;
  logic [REGSIZE-1:0] r_rdata;

  logic [1:0]         w_grant;
  logic               w_fire;
  logic               w_idle;

  assign w_idle = (r_state == IDLE);

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_idle),
    .i_valid ({req1_valid, req0_valid}),
    .o_grant (w_grant)
  );

  // A grant only exists for an asserted valid, so any grant is a handshake.
  assign w_fire     = |w_grant;
  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_fire) w_state_next = ACCESS;
      ACCESS:  w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_id    <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_fire) begin
        r_id    <= w_grant[1];
        r_write <= w_grant[1] ? req1_write : req0_write;
        r_addr  <= w_grant[1] ? req1_addr  : req0_addr;
        r_wdata <= w_grant[1] ? req1_wdata : req0_wdata;
      end
      // Stores return zero so a requester never sees stale load data.
      if (r_state == ACCESS) begin
        r_rdata <= r_write ? '0 : DMout;
      end
    end
  end

  // Memory port is driven only during ACCESS and is zero otherwise; since
  // reset forces IDLE asynchronously, a strobe in flight drops at once.
  assign Addr      = (r_state == ACCESS) ? r_addr  : '0;
  assign WriteData = (r_state == ACCESS) ? r_wdata : '0;
  assign MemWrite  = (r_state == ACCESS) &&  r_write;
  assign MemRead   = (r_state == ACCESS) && !r_write;

  assign rsp0_valid = (r_state == RESP) && !r_id;
  assign rsp1_valid = (r_state == RESP) &&  r_id;
  assign rsp0_rdata = r_rdata;
  assign rsp1_rdata = r_rdata;

  assign busy = (r_state == ACCESS) || (r_state == RESP);

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_write;
  logic [W-1:0] req0_addr, req0_wdata;
  logic         rsp0_valid;
  logic [W-1:0] rsp0_rdata;
  logic         req1_valid, req1_ready, req1_write;
  logic [W-1:0] req1_addr, req1_wdata;
  logic         rsp1_valid;
  logic [W-1:0] rsp1_rdata;
  logic [W-1:0] Addr, WriteData, DMout;
  logic         MemWrite, MemRead, busy;

  int errors = 0;
  int checks = 0;

  // Behavioural Data_memory: combinational read, write on rising edge.
  logic [W-1:0] mem [0:255];
  assign DMout = mem[Addr[7:0]];
  always @(posedge clk) begin
    if (MemWrite) mem[Addr[7:0]] <= WriteData;
  end

  dmem_arbiter #(.REGSIZE(64), .BITSIZE(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .Addr(Addr), .WriteData(WriteData), .MemWrite(MemWrite), .MemRead(MemRead),
    .DMout(DMout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h1E] = 64'h2;
    rst_n = 1'b0;
    req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_memwrite", MemWrite, 0);
    chk("rst_rsp0", rsp0_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load from 0x1E by req0
    req0_valid = 1; req0_write = 0; req0_addr = 64'h1E;
    #1;
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    step;                                   // ACCESS
    chk("t1_acc_ready0", req0_ready, 0);
    req0_valid = 0;
    chk("t1_memread", MemRead, 1);
    chk("t1_memwrite", MemWrite, 0);
    chk("t1_addr", Addr, 64'h1E);
    chk("t1_busy", busy, 1);
    step;                                   // RESP
    chk("t1_rsp0", rsp0_valid, 1);
    chk("t1_rsp1", rsp1_valid, 0);
    chk("t1_rdata", rsp0_rdata, 64'h2);
    chk("t1_resp_memread", MemRead, 0);
    chk("t1_resp_addr", Addr, 0);
    step;                                   // IDLE
    chk("t1_rsp0_off", rsp0_valid, 0);
    chk("t1_idle_busy", busy, 0);
    chk("t1_rdata_hold", rsp0_rdata, 64'h2);

    // Store 0x6 to 0x0B by req1, then load it back
    req1_valid = 1; req1_write = 1; req1_addr = 64'h0B; req1_wdata = 64'h6;
    #1;
    chk("t2_ready1", req1_ready, 1);
    step;                                   // ACCESS
    req1_valid = 0;
    chk("t2_memwrite", MemWrite, 1);
    chk("t2_memread", MemRead, 0);
    chk("t2_addr", Addr, 64'h0B);
    chk("t2_wdata", WriteData, 64'h6);
    step;                                   // RESP
    chk("t2_memwrite_off", MemWrite, 0);
    chk("t2_rsp1", rsp1_valid, 1);
    chk("t2_rsp0", rsp0_valid, 0);
    chk("t2_rdata", rsp1_rdata, 0);
    step;                                   // IDLE
    req1_valid = 1; req1_write = 0;
    #1;
    chk("t2b_ready1", req1_ready, 1);
    step; req1_valid = 0;
    step;                                   // RESP
    chk("t2b_rsp1", rsp1_valid, 1);
    chk("t2b_rdata", rsp1_rdata, 64'h6);
    step;                                   // IDLE

    // Both requesters valid continuously: grants alternate 0,1,0,1
    req0_valid = 1; req0_write = 0; req0_addr = 64'h1E;
    req1_valid = 1; req1_write = 0; req1_addr = 64'h0B;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3_ready0_%0d", k), req0_ready, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("t3_ready1_%0d", k), req1_ready, (k % 2 == 1) ? 1 : 0);
      step;                                 // ACCESS
      chk($sformatf("t3_addr_%0d", k), Addr, (k % 2 == 0) ? 64'h1E : 64'h0B);
      chk($sformatf("t3_accready_%0d", k), {req1_ready, req0_ready}, 0);
      step;                                 // RESP
      chk($sformatf("t3_rsp0_%0d", k), rsp0_valid, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("t3_rsp1_%0d", k), rsp1_valid, (k % 2 == 1) ? 1 : 0);
      chk($sformatf("t3_rdata_%0d", k), rsp0_rdata, (k % 2 == 0) ? 64'h2 : 64'h6);
      step;                                 // IDLE
    end
    req0_valid = 0; req1_valid = 0;

    // Reset during ACCESS of a store 0x7 -> 0x0D
    req0_valid = 1; req0_write = 1; req0_addr = 64'h0D; req0_wdata = 64'h7;
    #1;
    chk("t4_ready0", req0_ready, 1);
    step;                                   // ACCESS
    req0_valid = 0;
    chk("t4_memwrite", MemWrite, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t4_rst_memwrite", MemWrite, 0);
    chk("t4_rst_addr", Addr, 0);
    chk("t4_rst_busy", busy, 0);
    step;
    chk("t4_rst_rsp0", rsp0_valid, 0);
    chk("t4_mem_0d", mem[8'h0D], 0);
    rst_n = 1'b1;
    step;
    chk("t4_post_rsp0", rsp0_valid, 0);
    chk("t4_post_busy", busy, 0);

    // req1 valid one cycle while req0 wins (pointer reset to req0), then dropped
    req0_valid = 1; req0_write = 0; req0_addr = 64'h1E;
    req1_valid = 1; req1_write = 1; req1_addr = 64'h20; req1_wdata = 64'h9;
    #1;
    chk("t5_ready0", req0_ready, 1);
    chk("t5_ready1", req1_ready, 0);
    step;                                   // ACCESS
    req0_valid = 0; req1_valid = 0;
    chk("t5_addr", Addr, 64'h1E);
    step;                                   // RESP
    chk("t5_rsp0", rsp0_valid, 1);
    chk("t5_rsp1", rsp1_valid, 0);
    step;                                   // IDLE
    chk("t5_mem_20", mem[8'h20], 0);
    // Pointer moved only for req0, so req1 now wins a tie
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("t5_tie_ready1", req1_ready, 1);
    chk("t5_tie_ready0", req0_ready, 0);
    req0_valid = 0; req1_valid = 0;         // dropped before the edge
    step;
    chk("t5_drop_busy", busy, 0);
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("t5_nochange_ready1", req1_ready, 1);
    req0_valid = 0; req1_valid = 0;
    step;
    chk("t5_final_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL timeout errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
